// File: rtl/alu_defs_pkg.sv
// Shared execute-stage definitions: ALU/multiplier funct codes and the
// state encoding used by the sequential multiply unit.
package alu_defs_pkg;

   // Funct codes decoded by the ALU slices
   localparam logic [5:0] FUNCT_ADD   = 6'd32;
   localparam logic [5:0] FUNCT_SUB   = 6'd34;
   localparam logic [5:0] FUNCT_AND   = 6'd36;
   localparam logic [5:0] FUNCT_OR    = 6'd37;
   localparam logic [5:0] FUNCT_SLT   = 6'd42;

   // Funct codes handled by the HI/LO multiply unit
   localparam logic [5:0] FUNCT_MULTU = 6'd25;
   localparam logic [5:0] FUNCT_MFHI  = 6'd16;
   localparam logic [5:0] FUNCT_MFLO  = 6'd18;

   // Multiply sequencer states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/hi_lo_reg.sv
// HI/LO result register pair with a shared write enable and the MFHI/MFLO
// read mux. Kept separate so later MTHI/MTLO and DIVU logic can reuse it.
module hi_lo_reg
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [5:0]       funct,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Both halves load together; otherwise hold the last result
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (we) begin
         hi_d = hi_in;
         lo_d = lo_in;
      end
   end

   // Result registers, cleared by the active-low asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Read mux: only MFHI/MFLO drive a value, everything else reads as zero
   always_comb begin
      data_out = '0;
      if (funct == FUNCT_MFHI) begin
         data_out = hi_q;
      end else if (funct == FUNCT_MFLO) begin
         data_out = lo_q;
      end
   end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned shift-and-add multiplier. One iteration per clock;
// the 2*WIDTH-bit product lands in the HI/LO registers when finished.
module multu_hilo_unit
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] dataOut,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_LAST = '1;

   mul_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;
   logic               hilo_we;

   // Sequencer: accept MULTU in IDLE, then add-and-shift until the count wraps
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      hilo_we = 1'b0;
      sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      case (state_q)
         ST_IDLE: begin
            if (Signal == FUNCT_MULTU) begin
               mcand_d = dataA;
               prod_d  = {{WIDTH{1'b0}}, dataB};
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // The add carry shifts into the top product bit
            prod_d = {sum, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               hilo_we = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and datapath registers; reset aborts any multiply in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;

   // HI/LO capture the final iteration's product directly
   hi_lo_reg #(
      .WIDTH(WIDTH)
   ) u_hi_lo_reg (
      .clk     (clk),
      .reset   (reset),
      .we      (hilo_we),
      .hi_in   (prod_d[2*WIDTH-1:WIDTH]),
      .lo_in   (prod_d[WIDTH-1:0]),
      .funct   (Signal),
      .data_out(dataOut)
   );

endmodule
